// File: rtl/pe_incha_dual_sched_if.sv
// Handshake/bus bundle between the pixel source, PE, output buffer, downstream
// stage and the dual-output input-channel PE sequencer.
interface pe_incha_dual_sched_if #(
    parameter int OUT_CHANNEL = 17
);
    localparam int PAIRS = (OUT_CHANNEL + 1) / 2;
    localparam int AW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    logic          i_valid;
    logic          o_ready;
    logic          o_pix_latch;
    logic          o_pe_issue;
    logic [AW-1:0] o_wgt_addr;
    logic          o_issue_last;
    logic          i_obuf_valid;
    logic          o_out_valid;
    logic          i_out_ready;
    logic          o_busy;
    logic          o_err;

    // Environment side: pixel source, output buffer and downstream stage.
    modport master (
        output i_valid, i_obuf_valid, i_out_ready,
        input  o_ready, o_pix_latch, o_pe_issue, o_wgt_addr, o_issue_last,
               o_out_valid, o_busy, o_err
    );

    // Sequencer side.
    modport slave (
        input  i_valid, i_obuf_valid, i_out_ready,
        output o_ready, o_pix_latch, o_pe_issue, o_wgt_addr, o_issue_last,
               o_out_valid, o_busy, o_err
    );
endinterface

// File: rtl/pe_incha_dual_sched.sv
// Sequencer for one dual-output input-channel PE and its output buffer.
// Per accepted pixel it issues one step per output-channel pair, waits for the
// PE pipeline/buffer to flush, then holds the output vector until accepted.
module pe_incha_dual_sched #(
    parameter int OUT_CHANNEL = 17,
    parameter int PE_LATENCY  = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    pe_incha_dual_sched_if.slave    bus
);
    localparam int PAIRS = (OUT_CHANNEL + 1) / 2;
    localparam int AW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int FW    = (PE_LATENCY > 0) ? $clog2(PE_LATENCY + 1) : 1;

    localparam logic [AW-1:0] LAST_PAIR  = AW'(PAIRS - 1);
    localparam logic [FW-1:0] LAST_FLUSH = FW'(PE_LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        OUT
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] pair_cnt, pair_cnt_nxt;
    logic [FW-1:0] flush_cnt, flush_cnt_nxt;
    logic          err, err_nxt;

    logic          ready;
    logic          handshake;
    logic          pulse_due;

    // State, counter and sticky-error registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pair_cnt  <= '0;
            flush_cnt <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            pair_cnt  <= pair_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
            err       <= err_nxt;
        end
    end

    // Next-state, counters, error detection and state-decoded outputs.
    always_comb begin
        state_nxt     = state;
        pair_cnt_nxt  = pair_cnt;
        flush_cnt_nxt = flush_cnt;

        ready     = (state == IDLE) || ((state == OUT) && bus.i_out_ready);
        handshake = bus.i_valid && ready;
        pulse_due = (state == FLUSH) && (flush_cnt == LAST_FLUSH);

        // The buffer must complete exactly in the last flush cycle, never elsewhere.
        err_nxt = err || (bus.i_obuf_valid != pulse_due);

        unique case (state)
            IDLE: begin
                if (handshake) begin
                    pair_cnt_nxt = '0;
                    state_nxt    = RUN;
                end
            end
            RUN: begin
                if (pair_cnt == LAST_PAIR) begin
                    flush_cnt_nxt = '0;
                    state_nxt     = FLUSH;
                end else begin
                    pair_cnt_nxt = pair_cnt + 1'b1;
                end
            end
            FLUSH: begin
                if (flush_cnt == LAST_FLUSH) begin
                    state_nxt = OUT;
                end else begin
                    flush_cnt_nxt = flush_cnt + 1'b1;
                end
            end
            OUT: begin
                if (bus.i_out_ready) begin
                    if (bus.i_valid) begin
                        pair_cnt_nxt = '0;
                        state_nxt    = RUN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        bus.o_ready      = ready;
        bus.o_pix_latch  = handshake;
        bus.o_pe_issue   = (state == RUN);
        bus.o_wgt_addr   = (state == RUN) ? pair_cnt : '0;
        bus.o_issue_last = (state == RUN) && (pair_cnt == LAST_PAIR);
        bus.o_out_valid  = (state == OUT);
        bus.o_busy       = (state != IDLE);
        bus.o_err        = err;
    end
endmodule

// File: tb/tb_pe_incha_dual_sched.sv
// Self-checking bench: two sequencer instances (17 ch / latency 2 and
// 2 ch / latency 0) driven with shared directed and random stimulus and
// compared every cycle against a timeline-based reference model.
module tb_pe_incha_dual_sched;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pe_incha_dual_sched_if #(.OUT_CHANNEL(17)) bus_a ();
    pe_incha_dual_sched_if #(.OUT_CHANNEL(2))  bus_b ();

    pe_incha_dual_sched #(.OUT_CHANNEL(17), .PE_LATENCY(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );
    pe_incha_dual_sched #(.OUT_CHANNEL(2), .PE_LATENCY(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: each pixel is a timeline relative to its handshake cycle.
    int pairs [2] = '{9, 1};
    int lat   [2] = '{2, 0};
    bit busy  [2];
    int t0    [2];
    bit err_m [2];
    bit drop  [2];
    bit spur  [2];
    bit obv   [2];

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic do_cycle(input bit rst_v, input bit iv, input bit ordy);
        int       d;
        bit       due;
        bit       ready_e, latch_e, issue_e, last_e, ov_e;
        logic [3:0]  addr_e;
        logic [10:0] obs, exp;
        @(negedge clk);
        rst_n = rst_v;
        for (int id = 0; id < 2; id++) begin
            d   = cyc - t0[id];
            due = busy[id] && (d == pairs[id] + lat[id] + 1);
            obv[id] = due;
            if (drop[id] && due) begin
                obv[id]  = 1'b0;
                drop[id] = 1'b0;
            end
            if (spur[id]) begin
                obv[id]  = ~obv[id];
                spur[id] = 1'b0;
            end
        end
        bus_a.i_valid      = iv;
        bus_a.i_out_ready  = ordy;
        bus_a.i_obuf_valid = obv[0];
        bus_b.i_valid      = iv;
        bus_b.i_out_ready  = ordy;
        bus_b.i_obuf_valid = obv[1];
        #1;
        for (int id = 0; id < 2; id++) begin
            d       = cyc - t0[id];
            due     = busy[id] && (d == pairs[id] + lat[id] + 1);
            ready_e = 1'b0; issue_e = 1'b0; last_e = 1'b0; ov_e = 1'b0; addr_e = '0;
            if (!busy[id]) begin
                ready_e = 1'b1;
            end else if (d >= 1 && d <= pairs[id]) begin
                issue_e = 1'b1;
                addr_e  = 4'(d - 1);
                last_e  = (d == pairs[id]);
            end else if (d >= pairs[id] + lat[id] + 2) begin
                ov_e    = 1'b1;
                ready_e = ordy;
            end
            latch_e = ready_e && iv;
            exp = {ready_e, latch_e, issue_e, addr_e, last_e, ov_e, busy[id], err_m[id]};
            if (id == 0)
                obs = {bus_a.o_ready, bus_a.o_pix_latch, bus_a.o_pe_issue, 4'(bus_a.o_wgt_addr),
                       bus_a.o_issue_last, bus_a.o_out_valid, bus_a.o_busy, bus_a.o_err};
            else
                obs = {bus_b.o_ready, bus_b.o_pix_latch, bus_b.o_pe_issue, 4'(bus_b.o_wgt_addr),
                       bus_b.o_issue_last, bus_b.o_out_valid, bus_b.o_busy, bus_b.o_err};
            check((id == 0) ? "oc17_outputs" : "oc2_outputs", obs, exp);
            if (!rst_v) begin
                busy[id]  = 1'b0;
                err_m[id] = 1'b0;
            end else begin
                if (obv[id] != due) err_m[id] = 1'b1;
                if (latch_e) begin
                    busy[id] = 1'b1;
                    t0[id]   = cyc;
                end else if (ov_e && ordy) begin
                    busy[id] = 1'b0;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        rst_n = 1'b0;
        bus_a.i_valid = 1'b0; bus_a.i_out_ready = 1'b1; bus_a.i_obuf_valid = 1'b0;
        bus_b.i_valid = 1'b0; bus_b.i_out_ready = 1'b1; bus_b.i_obuf_valid = 1'b0;
        for (int id = 0; id < 2; id++) begin
            busy[id] = 1'b0; t0[id] = 0; err_m[id] = 1'b0;
            drop[id] = 1'b0; spur[id] = 1'b0; obv[id] = 1'b0;
        end
        repeat (2) @(posedge clk);

        // Reset state.
        repeat (2) do_cycle(1'b0, 1'b0, 1'b1);

        // Single pixel with ready downstream.
        do_cycle(1'b1, 1'b1, 1'b1);
        repeat (16) do_cycle(1'b1, 1'b0, 1'b1);

        // Continuous pixels, back-to-back.
        repeat (40) do_cycle(1'b1, 1'b1, 1'b1);

        // Downstream stall while the vector is held.
        repeat (30) do_cycle(1'b1, 1'b1, 1'b0);
        repeat (5)  do_cycle(1'b1, 1'b1, 1'b1);
        repeat (16) do_cycle(1'b1, 1'b0, 1'b1);

        // Reset mid-run, then a fresh pixel restarts at address 0.
        do_cycle(1'b1, 1'b1, 1'b1);
        repeat (4) do_cycle(1'b1, 1'b0, 1'b1);
        do_cycle(1'b0, 1'b0, 1'b1);
        do_cycle(1'b1, 1'b0, 1'b1);
        do_cycle(1'b1, 1'b1, 1'b1);
        repeat (14) do_cycle(1'b1, 1'b0, 1'b1);

        // Random traffic with well-behaved buffer pulses.
        repeat (800)
            do_cycle(1'b1, bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) != 0));
        repeat (20) do_cycle(1'b1, 1'b0, 1'b1);

        // Missing buffer pulse: sticky error until reset.
        drop[0] = 1'b1; drop[1] = 1'b1;
        do_cycle(1'b1, 1'b1, 1'b1);
        repeat (20) do_cycle(1'b1, 1'b0, 1'b1);
        do_cycle(1'b0, 1'b0, 1'b1);
        do_cycle(1'b1, 1'b0, 1'b1);

        // Spurious buffer pulse during a fresh run.
        do_cycle(1'b1, 1'b1, 1'b1);
        repeat (4) do_cycle(1'b1, 1'b0, 1'b1);
        spur[0] = 1'b1; spur[1] = 1'b1;
        repeat (20) do_cycle(1'b1, 1'b0, 1'b1);
        do_cycle(1'b0, 1'b0, 1'b1);
        repeat (3) do_cycle(1'b1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
